// File: rtl/text_edit_if.sv
// Editor-side handshake bundle for text_edit_ctrl: key commands in, cursor out,
// plus the display read port that shares the expression-buffer vector.
interface text_edit_if #(
  parameter int DATA_WIDTH   = 7,
  parameter int LENGTH_WIDTH = 7
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_op;
  logic [DATA_WIDTH-1:0]   cmd_char;
  logic                    cmd_done;
  logic                    cmd_err;
  logic [LENGTH_WIDTH-1:0] cursor;
  logic                    rd_req;
  logic [LENGTH_WIDTH-1:0] rd_index;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_char, rd_req, rd_index,
    input  cmd_ready, cmd_done, cmd_err, cursor, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, rd_req, rd_index,
    output cmd_ready, cmd_done, cmd_err, cursor, rd_valid, rd_data
  );
endinterface

// File: rtl/text_edit_ctrl.sv
// Sequencer/arbiter owning the expression-buffer vector port: turns editor key
// commands into get/insert/remove strobes, tracks the cursor, and serves display reads.
module text_edit_ctrl #(
  parameter int DATA_WIDTH   = 7,
  parameter int DATA_COUNT   = 127,
  parameter int INDEX_WIDTH  = $clog2(DATA_COUNT),
  parameter int LENGTH_WIDTH = $clog2(DATA_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  text_edit_if.slave              ed,
  output logic [INDEX_WIDTH-1:0]  vec_index,
  output logic                    vec_get,
  output logic                    vec_insert,
  output logic                    vec_remove,
  output logic [DATA_WIDTH-1:0]   vec_data_in,
  input  logic [DATA_WIDTH-1:0]   vec_data_out,
  input  logic [LENGTH_WIDTH-1:0] vec_length,
  input  logic                    vec_ready
);

  typedef enum logic [2:0] {
    SYNC, IDLE, RD_GET, RD_CAP, OP_ISSUE, OP_WAIT, CLR_CHECK
  } state_t;

  typedef enum logic [2:0] {
    KEY_INSERT, KEY_BKSP, KEY_DELETE, KEY_LEFT,
    KEY_RIGHT, KEY_HOME, KEY_END, KEY_CLEAR
  } key_t;

  typedef enum logic {GNT_CMD, GNT_RD} grant_t;

  localparam logic [LENGTH_WIDTH-1:0] FULL_LEN = LENGTH_WIDTH'(DATA_COUNT);
  localparam logic [LENGTH_WIDTH-1:0] ONE      = LENGTH_WIDTH'(1);

  state_t                  state;
  grant_t                  last_grant;
  key_t                    op_r;
  logic [LENGTH_WIDTH-1:0] cursor_r;
  logic                    cmd_done_r;
  logic                    cmd_err_r;
  logic                    rd_valid_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_grant;
  key_t                    key_in;

  // Round-robin: a pending read wins unless it was served last and a command waits.
  assign rd_grant = (state == IDLE) && ed.rd_req &&
                    ((last_grant == GNT_CMD) || !ed.cmd_valid);
  assign key_in   = key_t'(ed.cmd_op);

  assign ed.cmd_ready = (state == IDLE) && !rd_grant;
  assign ed.cmd_done  = cmd_done_r;
  assign ed.cmd_err   = cmd_err_r;
  assign ed.cursor    = cursor_r;
  assign ed.rd_valid  = rd_valid_r;
  assign ed.rd_data   = rd_data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      last_grant  <= GNT_CMD;
      op_r        <= KEY_INSERT;
      cursor_r    <= '0;
      cmd_done_r  <= 1'b0;
      cmd_err_r   <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= '0;
      vec_get     <= 1'b0;
      vec_insert  <= 1'b0;
      vec_remove  <= 1'b0;
      vec_index   <= '0;
      vec_data_in <= '0;
    end else begin
      cmd_done_r <= 1'b0;
      cmd_err_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      vec_get    <= 1'b0;
      vec_insert <= 1'b0;
      vec_remove <= 1'b0;
      case (state)
        SYNC: if (vec_ready) state <= IDLE;

        IDLE: begin
          if (rd_grant) begin
            last_grant <= GNT_RD;
            if (ed.rd_index >= vec_length) begin
              rd_valid_r <= 1'b1;
              rd_data_r  <= '0;
            end else begin
              vec_get   <= 1'b1;
              vec_index <= INDEX_WIDTH'(ed.rd_index);
              state     <= RD_GET;
            end
          end else if (ed.cmd_valid) begin
            last_grant <= GNT_CMD;
            op_r       <= key_in;
            case (key_in)
              KEY_INSERT: begin
                if (vec_length == FULL_LEN) begin
                  cmd_done_r <= 1'b1;
                  cmd_err_r  <= 1'b1;
                end else begin
                  vec_insert  <= 1'b1;
                  vec_index   <= INDEX_WIDTH'(cursor_r);
                  vec_data_in <= ed.cmd_char;
                  state       <= OP_ISSUE;
                end
              end
              KEY_BKSP: begin
                if (cursor_r == '0) begin
                  cmd_done_r <= 1'b1;
                  cmd_err_r  <= 1'b1;
                end else begin
                  vec_remove <= 1'b1;
                  vec_index  <= INDEX_WIDTH'(cursor_r - ONE);
                  state      <= OP_ISSUE;
                end
              end
              KEY_DELETE: begin
                if (cursor_r == vec_length) begin
                  cmd_done_r <= 1'b1;
                  cmd_err_r  <= 1'b1;
                end else begin
                  vec_remove <= 1'b1;
                  vec_index  <= INDEX_WIDTH'(cursor_r);
                  state      <= OP_ISSUE;
                end
              end
              KEY_LEFT: begin
                cmd_done_r <= 1'b1;
                if (cursor_r == '0) cmd_err_r <= 1'b1;
                else                cursor_r  <= cursor_r - ONE;
              end
              KEY_RIGHT: begin
                cmd_done_r <= 1'b1;
                if (cursor_r == vec_length) cmd_err_r <= 1'b1;
                else                        cursor_r  <= cursor_r + ONE;
              end
              KEY_HOME: begin
                cmd_done_r <= 1'b1;
                cursor_r   <= '0;
              end
              KEY_END: begin
                cmd_done_r <= 1'b1;
                cursor_r   <= vec_length;
              end
              default: state <= CLR_CHECK;
            endcase
          end
        end

        // vec_data_out becomes valid the cycle after the get strobe
        RD_GET: state <= RD_CAP;

        RD_CAP: begin
          rd_data_r  <= vec_data_out;
          rd_valid_r <= 1'b1;
          state      <= IDLE;
        end

        // vector drops ready the cycle after the strobe
        OP_ISSUE: state <= OP_WAIT;

        OP_WAIT: begin
          if (vec_ready) begin
            case (op_r)
              KEY_INSERT: cursor_r <= cursor_r + ONE;
              KEY_BKSP:   cursor_r <= cursor_r - ONE;
              KEY_CLEAR:  if (cursor_r > vec_length) cursor_r <= vec_length;
              default:    ;
            endcase
            if (op_r == KEY_CLEAR) begin
              state <= CLR_CHECK;
            end else begin
              cmd_done_r <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        // CLEAR pops from the tail so every remove takes the vector's fast path
        CLR_CHECK: begin
          if (vec_length == '0) begin
            cursor_r   <= '0;
            cmd_done_r <= 1'b1;
            state      <= IDLE;
          end else begin
            vec_remove <= 1'b1;
            vec_index  <= INDEX_WIDTH'(vec_length - ONE);
            state      <= OP_ISSUE;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule
